// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle datapath: one state per micro-step, strobes decoded from state.
// state     | meaning
// FETCH     | read instruction, PC <- PC + 1
// DECODE    | latch opcode, precompute branch target, dispatch
// MEM_ADDR  | compute load/store address
// MEM_READ  | read data memory
// MEM_WB    | write loaded word to register file
// MEM_WRITE | write data memory
// EXEC_R    | ALU op from funct field
// EXEC_I    | ALU add with immediate
// ALU_WB    | write ALU result to register file
// BRANCH    | compare, conditional PC load
// JUMP      | unconditional PC load from jump target
// HALT      | stopped until reset
module multicycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_out,
    output logic       halted
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        HALT      = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] opcode_q;
    ctrl_t      ctrl;

    function automatic state_t next_state(input state_t st, input logic [3:0] op,
                                          input logic [3:0] op_q);
        case (st)
            FETCH:     return DECODE;
            DECODE: begin
                case (op)
                    4'b0000:          return EXEC_R;
                    4'b0001:          return EXEC_I;
                    4'b0010, 4'b0011: return MEM_ADDR;
                    4'b0100, 4'b0101: return BRANCH;
                    4'b0110:          return JUMP;
                    4'b1111:          return HALT;
                    default:          return FETCH;
                endcase
            end
            MEM_ADDR:  return (op_q == 4'b0010) ? MEM_READ : MEM_WRITE;
            MEM_READ:  return MEM_WB;
            EXEC_R:    return ALU_WB;
            EXEC_I:    return ALU_WB;
            HALT:      return HALT;
            default:   return FETCH;
        endcase
    endfunction

    // Unlisted encodings decode to all-zero strobes.
    function automatic ctrl_t decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE:    c.alu_src_b = 2'b10;
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ALU_WB:    c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            HALT:      c.halted = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    assign state_nxt = next_state(state, opcode, opcode_q);

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= FETCH;
            opcode_q <= 4'b0000;
            ctrl     <= decode(FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= decode(state_nxt);
            if (state == DECODE)
                opcode_q <= opcode;
        end
    end

    // zero is only meaningful while the comparison is on the ALU, so it is not registered.
    assign PCWriteCond = (state == BRANCH) &&
                         (((opcode_q == 4'b0100) && zero) || ((opcode_q == 4'b0101) && !zero));

    assign PCWrite   = ctrl.pc_write;
    assign IRWrite   = ctrl.ir_write;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign RegWrite  = ctrl.reg_write;
    assign IorD      = ctrl.iord;
    assign MemToReg  = ctrl.mem_to_reg;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign PCSource  = ctrl.pc_source;
    assign halted    = ctrl.halted;
    assign state_out = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues expected per-cycle state and strobes,
// a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] opcode;
    logic       zero;
    logic       PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite;
    logic       IorD, MemToReg, ALUSrcA, halted;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_out;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state_out(state_out), .halted(halted)
    );

    always #5 CLK = ~CLK;

    wire [15:0] act = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
                       IorD, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};

    // Hand-written output table: {PCWrite,PCWriteCond,IRWrite,MemRead,MemWrite,RegWrite,
    // IorD,MemToReg,ALUSrcA,ALUSrcB,ALUOp,PCSource,halted}
    function automatic logic [15:0] exp_out(input logic [3:0] st, input logic [3:0] op,
                                            input logic z);
        case (st)
            4'd0:  return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd1:  return {9'b0, 2'b10, 2'b00, 2'b00, 1'b0};
            4'd2:  return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
            4'd3:  return {3'b0, 1'b1, 2'b00, 1'b1, 2'b00, 6'b0, 1'b0};
            4'd4:  return {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 1'b0};
            4'd5:  return {4'b0, 1'b1, 1'b0, 1'b1, 2'b00, 6'b0, 1'b0};
            4'd6:  return {8'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
            4'd7:  return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
            4'd8:  return {5'b0, 1'b1, 3'b0, 6'b0, 1'b0};
            4'd9:  return {1'b0, ((op == 4'b0100) ? z : ~z), 6'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
            4'd10: return {1'b1, 8'b0, 2'b00, 2'b00, 2'b10, 1'b0};
            4'd15: return {15'b0, 1'b1};
            default: return 16'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    // Drives one instruction from FETCH, queueing the expected state sequence; called at posedge+1 in FETCH.
    task automatic run_instr(input logic [3:0] op, input logic z, input int lim);
        logic [3:0] s[5];
        int n;
        exp_t e;
        s[0] = 4'd0; s[1] = 4'd1; s[2] = 4'd0; s[3] = 4'd0; s[4] = 4'd0;
        n = 2;
        case (op)
            4'b0000: begin s[2] = 4'd6; s[3] = 4'd8; n = 4; end
            4'b0001: begin s[2] = 4'd7; s[3] = 4'd8; n = 4; end
            4'b0010: begin s[2] = 4'd2; s[3] = 4'd3; s[4] = 4'd4; n = 5; end
            4'b0011: begin s[2] = 4'd2; s[3] = 4'd5; n = 4; end
            4'b0100, 4'b0101: begin s[2] = 4'd9; n = 3; end
            4'b0110: begin s[2] = 4'd10; n = 3; end
            4'b1111: begin s[2] = 4'd15; n = 3; end
            default: n = 2;
        endcase
        for (int k = 0; k < n && k < lim; k++) begin
            opcode = (s[k] == 4'd1) ? op : 4'($urandom);
            zero   = (s[k] == 4'd9) ? z : 1'($urandom);
            e.st = s[k];
            e.o  = exp_out(s[k], op, z);
            q.push_back(e);
            @(posedge CLK); #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: state=%0d with nothing expected", state_out);
                end else begin
                    e = q.pop_front();
                    if (state_out !== e.st || act !== e.o) begin
                        errors++;
                        $display("FAIL cycle: state=%0d out=%h expected state=%0d out=%h at %0t",
                                 state_out, act, e.st, e.o, $time);
                    end
                end
                checks++;
                if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
                    errors++;
                    $display("FAIL strobe_exclusive: MemRead=%b MemWrite=%b RegWrite=%b required no overlap",
                             MemRead, MemWrite, RegWrite);
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] op;
        exp_t e;
        Reset = 1'b1; opcode = 4'h0; zero = 1'b0;
        #2;
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_outputs", 32'(act), 32'(exp_out(4'd0, 4'd0, 1'b0)));
        @(posedge CLK); #1;
        chk("reset_hold", 32'(state_out), 32'd0);
        @(posedge CLK); #1;
        Reset  = 1'b0;
        mon_en = 1'b1;

        run_instr(4'b0010, 1'b0, 9);   // lw
        run_instr(4'b0011, 1'b0, 9);   // sw
        run_instr(4'b0000, 1'b0, 9);   // R-type
        run_instr(4'b0001, 1'b0, 9);   // addi
        run_instr(4'b0100, 1'b1, 9);   // beq taken
        run_instr(4'b0100, 1'b0, 9);   // beq not taken
        run_instr(4'b0101, 1'b1, 9);   // bne not taken
        run_instr(4'b0101, 1'b0, 9);   // bne taken
        run_instr(4'b0110, 1'b0, 9);   // jump
        run_instr(4'b1001, 1'b1, 9);   // illegal
        run_instr(4'b0010, 1'b1, 9);

        repeat (3700) begin
            op = 4'($urandom);
            if (op == 4'hF) op = 4'h9;
            run_instr(op, 1'($urandom), 9);
        end

        // Abort a store by asserting reset between edges.
        run_instr(4'b0011, 1'b0, 3);
        mon_en = 1'b0;
        chk("memwrite_before_reset", 32'(MemWrite), 32'd1);
        chk("state_before_reset", 32'(state_out), 32'd5);
        #2 Reset = 1'b1;
        #1;
        chk("memwrite_after_reset", 32'(MemWrite), 32'd0);
        chk("state_after_reset", 32'(state_out), 32'd0);
        @(posedge CLK); #1;
        chk("reset_no_advance", 32'(state_out), 32'd0);
        Reset  = 1'b0;
        mon_en = 1'b1;
        run_instr(4'b0010, 1'b0, 9);

        // Halt: stays put for 20 cycles regardless of opcode.
        run_instr(4'b1111, 1'b0, 3);
        repeat (19) begin
            opcode = 4'($urandom);
            zero   = 1'($urandom);
            e.st = 4'd15;
            e.o  = exp_out(4'd15, 4'hF, 1'b0);
            q.push_back(e);
            @(posedge CLK); #1;
        end
        mon_en = 1'b0;
        chk("halt_held", 32'(halted), 32'd1);
        Reset = 1'b1;
        #1;
        chk("halt_reset_state", 32'(state_out), 32'd0);
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide one clock and one reset: the reset is asynchronous and active-high.
REQ-002 SHALL have port CLK, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 4 bits: instruction opcode, sampled in DECODE only.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag, sampled in BRANCH only.
REQ-006 SHALL have port PCWrite, output, 1 bit: unconditional PC load enable.
REQ-007 SHALL have port PCWriteCond, output, 1 bit: PC load enable qualified by the branch condition.
REQ-008 SHALL have ports IRWrite, MemRead, MemWrite, RegWrite, IorD, MemToReg, ALUSrcA, each output, 1 bit: datapath strobes and mux selects.
REQ-009 SHALL have port ALUSrcB, output, 2 bits: 00 = B register, 01 = constant 1, 10 = sign-extended immediate.
REQ-010 SHALL have port ALUOp, output, 2 bits: 00 = add, 01 = subtract, 10 = use funct field.
REQ-011 SHALL have port PCSource, output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 SHALL have port state_out, output, 4 bits: current state encoding, for debug.
REQ-013 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-014 SHALL implement a Moore FSM; all outputs SHALL be decoded from the current state only.
REQ-015 SHALL use these state encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JUMP=10, HALT=15.
REQ-016 SHALL drive every output 0 in any state except as listed in REQ-017 to REQ-026.
REQ-017 In FETCH, SHALL drive MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1; next state DECODE.
REQ-018 In DECODE, SHALL drive ALUSrcB=10, ALUOp=00, and branch on opcode: 0000 to EXEC_R, 0001 to EXEC_I, 0010 or 0011 to MEM_ADDR, 0100 or 0101 to BRANCH, 0110 to JUMP, 1111 to HALT; any other opcode (illegal) SHALL return to FETCH as a NOP.
REQ-019 DECODE SHALL latch the opcode into an internal register, opcode_q, for use by later states.
REQ-020 In MEM_ADDR, SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEM_READ if opcode_q=0010, else MEM_WRITE.
REQ-021 In MEM_READ, SHALL drive MemRead=1, IorD=1; next state MEM_WB.
REQ-022 In MEM_WB, SHALL drive RegWrite=1, MemToReg=1; in MEM_WRITE, SHALL drive MemWrite=1, IorD=1; both SHALL go next to FETCH.
REQ-023 In EXEC_R, SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; in EXEC_I, SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; both SHALL go next to ALU_WB.
REQ-024 In ALU_WB, SHALL drive RegWrite=1, MemToReg=0; next state FETCH.
REQ-025 In BRANCH, SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, and PCWriteCond = zero for opcode_q=0100 (beq) or ~zero for 0101 (bne); next state FETCH.
REQ-026 In JUMP, SHALL drive PCWrite=1, PCSource=10; next state FETCH.
REQ-027 In HALT, SHALL drive halted=1 with all strobes 0, and SHALL remain in HALT until Reset.
REQ-028 Instruction latency, counted from FETCH entry to the next FETCH entry, SHALL be: lw 5 cycles; sw, R-type, addi 4 cycles; beq, bne, jump, illegal opcode 3 cycles (illegal = FETCH, DECODE, FETCH).
REQ-029 At most one of MemRead and MemWrite SHALL be high in any cycle; RegWrite and MemWrite SHALL never be high together.
REQ-030 Changes on opcode or zero outside their sampling state SHALL have no effect.
REQ-031 An unreachable state encoding SHALL transition to FETCH on the next clock edge, with all outputs 0 in that cycle.

Reset
REQ-032 Reset=1 SHALL immediately, without waiting for a clock edge, force the state to FETCH and opcode_q to 0000; outputs SHALL then show FETCH values, with state_out=0 and halted=0.
REQ-033 Reset asserted mid-instruction (for example in MEM_WRITE) SHALL abort the instruction; the state machine SHALL not advance while Reset is held.
REQ-034 After Reset deasserts, the first rising edge SHALL move the state from FETCH to DECODE.

Verification
REQ-035 The bench SHALL cover: opcode=0010 (lw) -> state_out sequence 0,1,2,3,4,0; MemRead=1 in MEM_READ; RegWrite=1 with MemToReg=1 in MEM_WB.
REQ-036 The bench SHALL cover: opcode=0100 (beq) with zero=1 -> PCWriteCond=1 in BRANCH; repeated with zero=0 -> PCWriteCond=0; opcode=0101 (bne) gives the inverse result.
REQ-037 The bench SHALL cover: opcode=1001 (illegal) -> state_out sequence 0,1,0; no RegWrite, MemWrite, or PCWriteCond pulse occurs.
REQ-038 The bench SHALL cover: opcode=1111 -> halted=1 and held for 20 cycles with opcode toggling; Reset then gives state_out=0 and halted=0.
REQ-039 The bench SHALL cover: Reset asserted between clock edges during MEM_WRITE -> MemWrite drops to 0 and state_out=0 before the next edge.
REQ-040 The bench SHALL cover: random opcode streams over 10k cycles -> the checks of REQ-029 hold every cycle and the latencies of REQ-028 hold for every instruction.
